// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO, MTHI/MTLO
// Optional: define MDU_FAST_MULT_EN for single-cycle MULT/MULTU.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_src_a,
   input  logic [WIDTH-1:0] i_src_b,
   input  logic             i_flush,
   input  logic             i_mthi,
   input  logic             i_mtlo,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [5:0]       r_cnt;
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div0;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_done;

   logic             w_accept;
   logic             w_fix_wr;
   logic             w_mt_ok;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_t;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   // Operands are reduced to magnitudes at launch; signs are reapplied in FIX.
   assign w_a_neg = ~i_op[0] & i_src_a[WIDTH-1];
   assign w_b_neg = ~i_op[0] & i_src_b[WIDTH-1];
   assign w_abs_a = w_a_neg ? -i_src_a : i_src_a;
   assign w_abs_b = w_b_neg ? -i_src_b : i_src_b;

   assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_div_t    = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_div_ge   = (w_div_t >= {1'b0, r_opnd});
   assign w_div_diff = w_div_t[WIDTH-1:0] - r_opnd;

`ifdef MDU_FAST_MULT_EN
   assign w_prod = {{WIDTH{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_acc_lo};
`else
   assign w_prod = {r_acc_hi, r_acc_lo};
`endif
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;

   always_comb begin
      w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_s[WIDTH-1:0];
      if (r_is_div) begin
         // Divide by zero yields all-ones quotient; remainder restores to src_a.
         w_res_lo = r_div0 ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
         w_res_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fix_wr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_flush) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ITER;
`ifdef MDU_FAST_MULT_EN
               if (!i_op[1]) w_state_nxt = S_FIX;
`endif
            end
         end
         S_ITER: begin
            if (i_flush)                 w_state_nxt = S_IDLE;
            else if (r_cnt == LAST_ITER) w_state_nxt = S_FIX;
         end
         S_FIX: begin
            w_state_nxt = S_IDLE;
            w_fix_wr    = !i_flush;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_mt_ok = (r_state == S_IDLE) && !w_accept;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_opnd   <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_fix_wr;
         if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= i_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (i_src_b == '0);
            r_acc_hi <= '0;
            r_opnd   <= i_op[1] ? w_abs_b : w_abs_a;
            r_acc_lo <= i_op[1] ? w_abs_a : w_abs_b;
         end else if (r_state == S_ITER && !i_flush) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_is_div) begin
               r_acc_hi <= w_div_ge ? w_div_diff : w_div_t[WIDTH-1:0];
               r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
            end else begin
               r_acc_hi <= w_mul_sum[WIDTH:1];
               r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
            end
         end
         if (w_fix_wr) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (w_mt_ok) begin
            if (i_mthi) r_hi <= i_wr_data;
            if (i_mtlo) r_lo <= i_wr_data;
         end
      end
   end

   assign o_busy = (r_state != S_IDLE);
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking scoreboard bench for mult_div_unit
module tb_mult_div_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst, start, flush, mthi, mtlo;
   logic [1:0]    op;
   logic [W-1:0]  a, b, wr;
   logic          busy, done;
   logic [W-1:0]  hi, lo;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] sb_q[$];

   mult_div_unit #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
      .i_src_a(a), .i_src_b(b), .i_flush(flush), .i_mthi(mthi),
      .i_mtlo(mtlo), .i_wr_data(wr), .o_busy(busy), .o_done(done),
      .o_hi(hi), .o_lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] sx, sy;
      int sa, sb, q, r;
      logic [31:0] qq, rr;
      case (o)
         2'b00: begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
         end
         2'b01: return {32'b0, x} * {32'b0, y};
         2'b10: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            sa = x; sb = y;
            q = sa / sb; r = sa % sb;
            qq = q; rr = r;
            return {rr, qq};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp += 4;
      if (hi !== 32'h0)  begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
      if (lo !== 32'h0)  begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
   endtask

   task automatic test_mult;
      logic [1:0]  t_op[3] = '{2'b01, 2'b00, 2'b00};
      logic [31:0] t_a[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
      logic [31:0] t_b[3]  = '{32'hFFFFFFFF, 32'h00000007, 32'h80000000};
      logic [63:0] t_e[3]  = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000};
      logic [63:0] e;
      int lat;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(t_e[i]);
         do_op(t_op[i], t_a[i], t_b[i], lat);
         e = sb_q.pop_front();
         n_cmp += 3;
         if (lat !== LAT)          begin n_err++; $display("FAIL mult%0d_latency: got %0d want %0d", i, lat, LAT); end
         if (hi !== e[63:32])      begin n_err++; $display("FAIL mult%0d_hi: got %h want %h", i, hi, e[63:32]); end
         if (lo !== e[31:0])       begin n_err++; $display("FAIL mult%0d_lo: got %h want %h", i, lo, e[31:0]); end
      end
   endtask

   task automatic test_div;
      logic [1:0]  t_op[6] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
      logic [31:0] t_a[6]  = '{32'hFFFFFFF9, 32'd100, 32'd10, 32'd10, 32'h80000000, 32'hFFFFFFF6};
      logic [31:0] t_b[6]  = '{32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};
      logic [63:0] t_e[6]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E,
                               64'h0000000A_FFFFFFFF, 64'h0000000A_FFFFFFFF,
                               64'h00000000_80000000, 64'hFFFFFFF6_FFFFFFFF};
      logic [63:0] e;
      int lat;
      for (int i = 0; i < 6; i++) begin
         sb_q.push_back(t_e[i]);
         do_op(t_op[i], t_a[i], t_b[i], lat);
         e = sb_q.pop_front();
         n_cmp += 3;
         if (lat !== LAT)          begin n_err++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, LAT); end
         if (hi !== e[63:32])      begin n_err++; $display("FAIL div%0d_hi: got %h want %h", i, hi, e[63:32]); end
         if (lo !== e[31:0])       begin n_err++; $display("FAIL div%0d_lo: got %h want %h", i, lo, e[31:0]); end
      end
   endtask

   task automatic test_random;
      logic [1:0]  o;
      logic [31:0] x, y;
      logic [63:0] e;
      int lat;
      for (int i = 0; i < 8; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i[1:0] == 2'b11) y = -y;
         sb_q.push_back(model(o, x, y));
         do_op(o, x, y, lat);
         e = sb_q.pop_front();
         n_cmp += 2;
         if (lat !== LAT) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, LAT); end
         if ({hi, lo} !== e) begin n_err++; $display("FAIL rand%0d_op%0d a=%h b=%h: got %h_%h want %h", i, o, x, y, hi, lo, e); end
      end
   endtask

   task automatic test_start_while_busy;
      logic [63:0] e;
      int lat = 0;
      logic busy_at5 = 1'b0;
      sb_q.push_back(64'h00000001_0000014D);
      start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         if (k == 4) begin start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5; end
         @(posedge clk); #1;
         if (k == 4) begin start = 1'b0; busy_at5 = busy; end
         if (done) begin lat = k; break; end
      end
      e = sb_q.pop_front();
      n_cmp += 3;
      if (busy_at5 !== 1'b1)  begin n_err++; $display("FAIL busy_ignore_busy: got %b want 1", busy_at5); end
      if (lat !== LAT)        begin n_err++; $display("FAIL busy_ignore_latency: got %0d want %0d", lat, LAT); end
      if ({hi, lo} !== e)     begin n_err++; $display("FAIL busy_ignore_result: got %h_%h want %h", hi, lo, e); end
   endtask

   task automatic test_flush;
      logic [63:0] e;
      int lat;
      int saw_done = 0;
      logic busy_pre = 1'b0;
      sb_q.push_back(64'h00000002_0000000E);
      do_op(2'b11, 32'd100, 32'd7, lat);
      e = sb_q.pop_front();
      n_cmp++;
      if ({hi, lo} !== e) begin n_err++; $display("FAIL flush_setup: got %h_%h want %h", hi, lo, e); end
      start = 1'b1; op = 2'b10; a = 32'd77; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (k == 5) start = 1'b1;
         @(posedge clk); #1;
         if (k == 5) start = 1'b0;
         if (done) saw_done++;
      end
      busy_pre = busy;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp += 2;
      if (busy_pre !== 1'b1) begin n_err++; $display("FAIL flush_busy_before: got %b want 1", busy_pre); end
      if (busy !== 1'b0)     begin n_err++; $display("FAIL flush_busy_after: got %b want 0", busy); end
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) saw_done++;
      end
      n_cmp += 2;
      if (saw_done !== 0)  begin n_err++; $display("FAIL flush_no_done: got %0d pulses want 0", saw_done); end
      if ({hi, lo} !== e)  begin n_err++; $display("FAIL flush_hilo_kept: got %h_%h want %h", hi, lo, e); end
      start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_same_cycle: busy got %b want 0", busy); end
   endtask

   task automatic test_rst_mid;
      int saw_done = 0;
      start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd11;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp += 4;
      if (hi !== 32'h0)  begin n_err++; $display("FAIL rstmid_hi: got %h want 0", hi); end
      if (lo !== 32'h0)  begin n_err++; $display("FAIL rstmid_lo: got %h want 0", lo); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done) saw_done++;
      end
      n_cmp++;
      if (saw_done !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses want 0", saw_done); end
   endtask

   task automatic test_mt;
      logic [63:0] e;
      int lat;
      mthi = 1'b1; wr = 32'h1234;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b1; wr = 32'h5678;
      n_cmp += 3;
      if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
      if (done !== 1'b0)   begin n_err++; $display("FAIL mthi_done: got %b want 0", done); end
      if (busy !== 1'b0)   begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      mtlo = 1'b0;
      n_cmp += 2;
      if (lo !== 32'h5678) begin n_err++; $display("FAIL mtlo_lo: got %h want 00005678", lo); end
      if (hi !== 32'h1234) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want 00001234", hi); end
      mthi = 1'b1; mtlo = 1'b1; wr = 32'hAAAA;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      n_cmp++;
      if ({hi, lo} !== {32'hAAAA, 32'hAAAA}) begin n_err++; $display("FAIL mt_both: got %h_%h want 0000aaaa_0000aaaa", hi, lo); end
      sb_q.push_back(64'h00000000_00000010);
      start = 1'b1; op = 2'b01; a = 32'd4; b = 32'd4; mthi = 1'b1; wr = 32'hBEEF;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      mthi = 1'b0;
      n_cmp++;
      if (hi !== 32'hAAAA) begin n_err++; $display("FAIL mt_while_busy: got %h want 0000aaaa", hi); end
      lat = 0;
      for (int k = 2; k <= 100; k++) begin
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
      end
      e = sb_q.pop_front();
      n_cmp += 2;
      if (lat !== LAT)    begin n_err++; $display("FAIL mt_start_wins_latency: got %0d want %0d", lat, LAT); end
      if ({hi, lo} !== e) begin n_err++; $display("FAIL mt_start_wins_result: got %h_%h want %h", hi, lo, e); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] e;
      int lat1, lat2;
      sb_q.push_back(model(2'b00, 32'hFFFFFF00, 32'h00001234));
      sb_q.push_back(model(2'b10, 32'h12345678, 32'hFFFFFF9C));
      do_op(2'b00, 32'hFFFFFF00, 32'h00001234, lat1);
      e = sb_q.pop_front();
      n_cmp += 2;
      if (lat1 !== LAT)   begin n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", lat1, LAT); end
      if ({hi, lo} !== e) begin n_err++; $display("FAIL b2b_first_result: got %h_%h want %h", hi, lo, e); end
      do_op(2'b10, 32'h12345678, 32'hFFFFFF9C, lat2);
      e = sb_q.pop_front();
      n_cmp += 2;
      if (lat2 !== LAT)   begin n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat2, LAT); end
      if ({hi, lo} !== e) begin n_err++; $display("FAIL b2b_second_result: got %h_%h want %h", hi, lo, e); end
      @(posedge clk); #1;
      n_cmp += 2;
      if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_one_cycle: got %b want 0", done); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 2'b00; a = '0; b = '0; wr = '0;
      #1;
      test_reset;
      test_mult;
      test_div;
      test_random;
      test_start_while_busy;
      test_flush;
      test_rst_mid;
      test_mt;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
